// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity-select codes and
// the data width, used by both receiver and transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;

  // Parity-select codes; 2'b11 behaves like the constant-zero setting.
  localparam logic [1:0] PAR_ZERO     = 2'b00;
  localparam logic [1:0] PAR_XOR      = 2'b01;
  localparam logic [1:0] PAR_XNOR     = 2'b10;
  localparam logic [1:0] PAR_ZERO_ALT = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DATA   = 2'b01,
    PARITY = 2'b10,
    STOP   = 2'b11
  } uart_state_e;

  // Parity value the line is expected to carry for a given byte.
  function automatic logic expected_parity(input logic [1:0] sel,
                                           input logic [DATA_BITS-1:0] data);
    case (sel)
      PAR_XOR:  return ^data;
      PAR_XNOR: return ~^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Resets to the
// idle-high level so a reset never looks like a start bit.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s
);

  logic [STAGES-1:0] sync_reg;

  // Shift the raw line through the flop chain; oldest stage is the output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start bit, 8 data bits LSB-first, optional parity bit,
// one stop bit. Advances only on baud ticks (inrx). The received frame is
// held until the consumer accepts it with rx_ready; a frame completing
// while one is still held is dropped and flagged as overrun.
// Build option: define UART_RX_PARITY_EN for 11-bit frames with a parity
// bit; otherwise frames are 10 bits and parity_err is always 0.
module uart_receiver
  import uart_pkg::*;
#(
  parameter logic [1:0] PARITY_SEL = PAR_XOR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 inrx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  logic rx_s;

  uart_rx_sync #(.STAGES(2)) u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s)
  );

  uart_state_e          state_reg, state_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_mismatch_reg, par_mismatch_next;
  logic                 publish;

  logic [DATA_BITS-1:0] data_out_reg, data_out_next;
  logic                 rx_valid_reg, rx_valid_next;
  logic                 parity_err_reg, parity_err_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 overrun_err_reg, overrun_err_next;

  // Frame-assembly state: FSM, bit counter, shift register, parity mismatch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg        <= IDLE;
      count_reg        <= '0;
      shift_reg        <= '0;
      par_mismatch_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      count_reg        <= count_next;
      shift_reg        <= shift_next;
      par_mismatch_reg <= par_mismatch_next;
    end
  end

  // Next-state logic; nothing moves except on a baud tick.
  always_comb begin
    state_next        = state_reg;
    count_next        = count_reg;
    shift_next        = shift_reg;
    par_mismatch_next = par_mismatch_reg;
    publish           = 1'b0;
    if (inrx) begin
      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            state_next        = DATA;
            count_next        = '0;
            par_mismatch_next = 1'b0;
          end
        end
        DATA: begin
          shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
          count_next = count_reg + 1'b1;
          if (count_reg == CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          par_mismatch_next = rx_s ^ expected_parity(PARITY_SEL, shift_reg);
          state_next        = STOP;
        end
`endif
        STOP: begin
          // Back to IDLE regardless of the stop level; a low stop bit is
          // only a framing error, never a new start.
          publish    = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output holding register and handshake/overrun next-value logic.
  always_comb begin
    data_out_next    = data_out_reg;
    rx_valid_next    = rx_valid_reg;
    parity_err_next  = parity_err_reg;
    frame_err_next   = frame_err_reg;
    overrun_err_next = overrun_err_reg;
    if (publish && (!rx_valid_reg || rx_ready)) begin
      // Slot is free, or being freed this cycle: take the new frame.
      data_out_next    = shift_reg;
      rx_valid_next    = 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_err_next  = par_mismatch_reg;
`else
      parity_err_next  = 1'b0;
`endif
      frame_err_next   = ~rx_s;
      overrun_err_next = 1'b0;
    end else if (publish) begin
      // Held frame not yet consumed: drop the new one.
      overrun_err_next = 1'b1;
    end else if (rx_valid_reg && rx_ready) begin
      rx_valid_next    = 1'b0;
      parity_err_next  = 1'b0;
      frame_err_next   = 1'b0;
      overrun_err_next = 1'b0;
    end
  end

  // Register the published frame and its status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out_reg    <= '0;
      rx_valid_reg    <= 1'b0;
      parity_err_reg  <= 1'b0;
      frame_err_reg   <= 1'b0;
      overrun_err_reg <= 1'b0;
    end else begin
      data_out_reg    <= data_out_next;
      rx_valid_reg    <= rx_valid_next;
      parity_err_reg  <= parity_err_next;
      frame_err_reg   <= frame_err_next;
      overrun_err_reg <= overrun_err_next;
    end
  end

  assign data_out    = data_out_reg;
  assign rx_valid    = rx_valid_reg;
  assign parity_err  = parity_err_reg;
  assign frame_err   = frame_err_reg;
  assign overrun_err = overrun_err_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver (PARITY_SEL = 2'b01). Works with
// UART_RX_PARITY_EN defined (11-bit frames) or undefined (10-bit frames).
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       inrx;
  logic       rx_ready;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_receiver #(.PARITY_SEL(2'b01)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .inrx        (inrx),
    .rx_ready    (rx_ready),
    .data_out    (data_out),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bit period: 5 clocks, tick on the 5th. Returns 1ns after the tick
  // edge so registered results of that tick are already visible.
  task automatic send_bit(input logic b, input logic rdy);
    rx = b;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    inrx     = 1'b1;
    rx_ready = rdy;
    @(posedge clk);
    #1;
    inrx     = 1'b0;
    rx_ready = 1'b0;
  endtask

  // Full frame; pflip inverts the correct (XOR) parity bit, stopb is the
  // stop level, rdy_on_stop asserts rx_ready in the stop-tick cycle.
  task automatic send_frame(input logic [7:0] d, input logic pflip,
                            input logic stopb, input logic rdy_on_stop);
    send_bit(1'b0, 1'b0);
    check("busy_after_start", {7'b0, busy}, 8'h01);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ pflip, 1'b0);
`endif
    send_bit(stopb, rdy_on_stop);
    rx = 1'b1;
    $display("frame %02h pflip=%0b stop=%0b -> data=%02h v=%0b pe=%0b fe=%0b oe=%0b",
             d, pflip, stopb, data_out, rx_valid, parity_err, frame_err, overrun_err);
  endtask

  task automatic handshake();
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] d, input logic v,
                               input logic pe, input logic fe, input logic oe);
    check({tag, "_data"}, data_out, d);
    check({tag, "_valid"}, {7'b0, rx_valid}, {7'b0, v});
    check({tag, "_perr"}, {7'b0, parity_err}, {7'b0, pe});
    check({tag, "_ferr"}, {7'b0, frame_err}, {7'b0, fe});
    check({tag, "_oerr"}, {7'b0, overrun_err}, {7'b0, oe});
  endtask

  initial begin
    reset    = 1'b0;
    rx       = 1'b1;
    inrx     = 1'b0;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_busy", {7'b0, busy}, 8'h00);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Good frame 0xA5
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    check_outputs("good", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("good_idle", {7'b0, busy}, 8'h00);
    handshake();
    check_outputs("good_ack", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
    // Parity bit inverted
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    check_outputs("parity", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    handshake();
    check_outputs("parity_ack", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // All-ones byte: parity must read clean
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    check_outputs("ff", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    handshake();

    // Stop bit low -> framing error, back to IDLE without restarting
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check_outputs("frame", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    check("frame_idle", {7'b0, busy}, 8'h00);
    send_bit(1'b1, 1'b0);
    check("frame_stay_idle", {7'b0, busy}, 8'h00);
    handshake();
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    check_outputs("after_frame", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    handshake();

    // Overrun: second frame lost while first held
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    check_outputs("overrun", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    handshake();
    check_outputs("overrun_ack", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

    // Publish in the same cycle as a handshake: new frame loads, no overrun
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
    check_outputs("pub_ack", 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset after 4 data bits of 0xF0 (frame 0xC3 still held)
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    rx    = 1'b1;
    check_outputs("midreset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midreset_busy", {7'b0, busy}, 8'h00);
    send_bit(1'b1, 1'b0);
    check("midreset_idle", {7'b0, busy}, 8'h00);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    check_outputs("after_reset", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    handshake();

    // Idle line for 20 ticks
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b1, 1'b0);
      check("idle_busy", {7'b0, busy}, 8'h00);
    end
    check("idle_valid", {7'b0, rx_valid}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
